// File: rtl/alu_writeback.sv
// ALU result writeback stage. A 2-entry in-order queue feeds a register file.
// Carry/zero flags update on every retire, and the operand read ports forward in-flight writes.
module alu_writeback #(
    parameter int WIDTH = 20,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [WIDTH-1:0] res_data,
    input  logic             res_cout,
    input  logic             res_we,
    input  logic [AW-1:0]    res_dest,
    input  logic             dbg_we,
    input  logic [AW-1:0]    dbg_addr,
    input  logic [WIDTH-1:0] dbg_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             pend_a,
    output logic             pend_b,
    output logic             flag_c,
    output logic             flag_z,
    output logic             wb_valid,
    output logic [AW-1:0]    wb_addr
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] q_data [2];
    logic             q_cout [2];
    logic             q_we   [2];
    logic [AW-1:0]    q_dest [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       occ;
    logic [WIDTH-1:0] rf [DEPTH];

    logic             accept;
    logic             retire;
    logic [WIDTH-1:0] head_data;
    logic             head_cout;
    logic             head_we;
    logic [AW-1:0]    head_dest;

    // Ready looks only at registered occupancy, never at a same-cycle retire.
    assign res_ready = rst_n && (count != 2'd2);
    assign accept    = res_valid && res_ready;
    assign retire    = rst_n && (count != 2'd0) && !dbg_we;

    assign head_data = q_data[rd_ptr];
    assign head_cout = q_cout[rd_ptr];
    assign head_we   = q_we[rd_ptr];
    assign head_dest = q_dest[rd_ptr];

    assign occ[0] = (count == 2'd2) || ((count == 2'd1) && !rd_ptr);
    assign occ[1] = (count == 2'd2) || ((count == 2'd1) && rd_ptr);

    always_comb begin
        pend_a = 1'b0;
        pend_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (occ[i] && q_we[i]) begin
                if (q_dest[i] == rd_addr_a) pend_a = 1'b1;
                if (q_dest[i] == rd_addr_b) pend_b = 1'b1;
            end
        end
    end

    // Debug write wins the forward; it also stalls retire, so both never hit together.
    always_comb begin
        rd_data_a = rf[rd_addr_a];
        if (dbg_we && (dbg_addr == rd_addr_a))
            rd_data_a = dbg_data;
        else if (retire && head_we && (head_dest == rd_addr_a))
            rd_data_a = head_data;
    end

    always_comb begin
        rd_data_b = rf[rd_addr_b];
        if (dbg_we && (dbg_addr == rd_addr_b))
            rd_data_b = dbg_data;
        else if (retire && head_we && (head_dest == rd_addr_b))
            rd_data_b = head_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            flag_c   <= 1'b0;
            flag_z   <= 1'b0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else begin
            if (accept) begin
                q_data[wr_ptr] <= res_data;
                q_cout[wr_ptr] <= res_cout;
                q_we[wr_ptr]   <= res_we;
                q_dest[wr_ptr] <= res_dest;
                wr_ptr         <= ~wr_ptr;
            end
            if (retire) begin
                rd_ptr  <= ~rd_ptr;
                flag_c  <= head_cout;
                flag_z  <= (head_data == '0);
                wb_addr <= head_dest;
                if (head_we) rf[head_dest] <= head_data;
            end
            if (dbg_we) rf[dbg_addr] <= dbg_data;
            wb_valid <= retire;
            case ({accept, retire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: reset, basic write, flags-only, backpressure,
// forwarding/pending, debug collision and mid-operation reset.
module tb_alu_writeback;

    localparam int WIDTH = 20;
    localparam int AW    = 4;

    logic             clk;
    logic             rst_n;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_cout;
    logic             res_we;
    logic [AW-1:0]    res_dest;
    logic             dbg_we;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             pend_a;
    logic             pend_b;
    logic             flag_c;
    logic             flag_z;
    logic             wb_valid;
    logic [AW-1:0]    wb_addr;

    int errors = 0;
    int checks = 0;

    alu_writeback #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cout(res_cout), .res_we(res_we), .res_dest(res_dest),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .pend_a(pend_a), .pend_b(pend_b),
        .flag_c(flag_c), .flag_z(flag_z),
        .wb_valid(wb_valid), .wb_addr(wb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [WIDTH-1:0] d, input logic c, input logic w,
                         input logic [AW-1:0] dst);
        res_valid = 1'b1;
        res_data  = d;
        res_cout  = c;
        res_we    = w;
        res_dest  = dst;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", res_ready); end
        checks++; if (flag_c !== 1'b0 || flag_z !== 1'b0) begin errors++; $display("FAIL reset_flags got c=%0b z=%0b exp 0/0", flag_c, flag_z); end
        checks++; if (wb_valid !== 1'b0 || wb_addr !== 4'd0) begin errors++; $display("FAIL reset_wb got v=%0b a=%0d exp 0/0", wb_valid, wb_addr); end
        rst_n = 1'b1;
        #1;
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%0b exp=1", res_ready); end
    endtask

    task automatic test_basic_write();
        offer(20'h0ABCD, 1'b1, 1'b1, 4'd3);
        tick();
        res_valid = 1'b0;
        rd_addr_a = 4'd3;
        #1;
        checks++; if (pend_a !== 1'b1) begin errors++; $display("FAIL basic_pend got=%0b exp=1", pend_a); end
        checks++; if (rd_data_a !== 20'h0ABCD) begin errors++; $display("FAIL basic_bypass got=%h exp=0abcd", rd_data_a); end
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd3) begin errors++; $display("FAIL basic_wb got v=%0b a=%0d exp 1/3", wb_valid, wb_addr); end
        checks++; if (flag_c !== 1'b1 || flag_z !== 1'b0) begin errors++; $display("FAIL basic_flags got c=%0b z=%0b exp 1/0", flag_c, flag_z); end
        checks++; if (rd_data_a !== 20'h0ABCD || pend_a !== 1'b0) begin errors++; $display("FAIL basic_rf got=%h pend=%0b exp 0abcd/0", rd_data_a, pend_a); end
        tick();
        checks++; if (wb_valid !== 1'b0 || wb_addr !== 4'd3) begin errors++; $display("FAIL basic_wb_hold got v=%0b a=%0d exp 0/3", wb_valid, wb_addr); end
    endtask

    task automatic test_flags_only();
        dbg_we = 1'b1; dbg_addr = 4'd5; dbg_data = 20'h12345;
        tick();
        dbg_we = 1'b0;
        offer(20'h00000, 1'b0, 1'b0, 4'd5);
        rd_addr_b = 4'd5;
        tick();
        res_valid = 1'b0;
        #1;
        checks++; if (pend_b !== 1'b0) begin errors++; $display("FAIL flagsonly_pend got=%0b exp=0", pend_b); end
        checks++; if (rd_data_b !== 20'h12345) begin errors++; $display("FAIL flagsonly_nobypass got=%h exp=12345", rd_data_b); end
        tick();
        checks++; if (flag_z !== 1'b1 || flag_c !== 1'b0) begin errors++; $display("FAIL flagsonly_flags got c=%0b z=%0b exp 0/1", flag_c, flag_z); end
        checks++; if (rd_data_b !== 20'h12345) begin errors++; $display("FAIL flagsonly_rf got=%h exp=12345", rd_data_b); end
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd5) begin errors++; $display("FAIL flagsonly_wb got v=%0b a=%0d exp 1/5", wb_valid, wb_addr); end
    endtask

    task automatic test_back_to_back();
        dbg_we = 1'b1; dbg_addr = 4'd15; dbg_data = 20'h0F0F0;
        offer(20'h00001, 1'b0, 1'b1, 4'd8);
        #1;
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got=%0b exp=1", res_ready); end
        tick();
        offer(20'h00002, 1'b1, 1'b1, 4'd9);
        #1;
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got=%0b exp=1", res_ready); end
        tick();
        offer(20'h00003, 1'b0, 1'b1, 4'd10);
        #1;
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL bp_full got=%0b exp=0", res_ready); end
        tick();
        rd_addr_a = 4'd8;
        #1;
        checks++; if (res_ready !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL bp_stall got rdy=%0b wbv=%0b exp 0/0", res_ready, wb_valid); end
        checks++; if (pend_a !== 1'b1) begin errors++; $display("FAIL bp_pend got=%0b exp=1", pend_a); end
        dbg_we = 1'b0;
        #1;
        checks++; if (res_ready !== 1'b0 || rd_data_a !== 20'h00001) begin errors++; $display("FAIL bp_release got rdy=%0b data=%h exp 0/00001", res_ready, rd_data_a); end
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd8 || flag_c !== 1'b0) begin errors++; $display("FAIL bp_retA got v=%0b a=%0d c=%0b exp 1/8/0", wb_valid, wb_addr, flag_c); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got=%0b exp=1", res_ready); end
        tick();
        res_valid = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd9 || flag_c !== 1'b1) begin errors++; $display("FAIL bp_retB got v=%0b a=%0d c=%0b exp 1/9/1", wb_valid, wb_addr, flag_c); end
        tick();
        rd_addr_a = 4'd15;
        rd_addr_b = 4'd10;
        #1;
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd10 || flag_c !== 1'b0) begin errors++; $display("FAIL bp_retC got v=%0b a=%0d c=%0b exp 1/10/0", wb_valid, wb_addr, flag_c); end
        checks++; if (rd_data_b !== 20'h00003 || rd_data_a !== 20'h0F0F0) begin errors++; $display("FAIL bp_rf got b=%h a=%h exp 00003/0f0f0", rd_data_b, rd_data_a); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%0b exp=0", wb_valid); end
    endtask

    task automatic test_bypass_pending();
        rd_addr_a = 4'd7;
        dbg_we = 1'b1; dbg_addr = 4'd0; dbg_data = 20'h00111;
        offer(20'h55AA5, 1'b0, 1'b1, 4'd7);
        #1;
        checks++; if (pend_a !== 1'b0) begin errors++; $display("FAIL byp_pend_empty got=%0b exp=0", pend_a); end
        tick();
        res_valid = 1'b0;
        #1;
        checks++; if (pend_a !== 1'b1 || rd_data_a !== 20'h00000) begin errors++; $display("FAIL byp_queued got pend=%0b data=%h exp 1/00000", pend_a, rd_data_a); end
        tick();
        checks++; if (pend_a !== 1'b1) begin errors++; $display("FAIL byp_stalled got=%0b exp=1", pend_a); end
        dbg_we = 1'b0;
        #1;
        checks++; if (pend_a !== 1'b1 || rd_data_a !== 20'h55AA5) begin errors++; $display("FAIL byp_retire_cycle got pend=%0b data=%h exp 1/55aa5", pend_a, rd_data_a); end
        tick();
        rd_addr_b = 4'd0;
        #1;
        checks++; if (pend_a !== 1'b0 || rd_data_a !== 20'h55AA5) begin errors++; $display("FAIL byp_after got pend=%0b data=%h exp 0/55aa5", pend_a, rd_data_a); end
        checks++; if (rd_data_b !== 20'h00111) begin errors++; $display("FAIL byp_addr0 got=%h exp=00111", rd_data_b); end
    endtask

    task automatic test_dbg_collision();
        rd_addr_a = 4'd2;
        rd_addr_b = 4'd4;
        dbg_we = 1'b1; dbg_addr = 4'd2; dbg_data = 20'h0DEAD;
        offer(20'h22222, 1'b1, 1'b1, 4'd2);
        #1;
        checks++; if (rd_data_a !== 20'h0DEAD) begin errors++; $display("FAIL coll_dbg_fwd got=%h exp=0dead", rd_data_a); end
        tick();
        res_valid = 1'b0;
        dbg_addr = 4'd4; dbg_data = 20'h00044;
        #1;
        checks++; if (rd_data_a !== 20'h0DEAD || pend_a !== 1'b1) begin errors++; $display("FAIL coll_dbg_first got=%h pend=%0b exp 0dead/1", rd_data_a, pend_a); end
        tick();
        dbg_we = 1'b0;
        #1;
        checks++; if (rd_data_a !== 20'h22222) begin errors++; $display("FAIL coll_fwd got=%h exp=22222", rd_data_a); end
        tick();
        checks++; if (rd_data_a !== 20'h22222 || wb_addr !== 4'd2 || flag_c !== 1'b1) begin errors++; $display("FAIL coll_overwrite got=%h a=%0d c=%0b exp 22222/2/1", rd_data_a, wb_addr, flag_c); end
        checks++; if (rd_data_b !== 20'h00044) begin errors++; $display("FAIL coll_dbg4 got=%h exp=00044", rd_data_b); end
    endtask

    task automatic test_reset_mid();
        dbg_we = 1'b1; dbg_addr = 4'd1; dbg_data = 20'h11111;
        offer(20'h00D0D, 1'b1, 1'b1, 4'd11);
        tick();
        offer(20'h00E0E, 1'b0, 1'b1, 4'd12);
        tick();
        rd_addr_a = 4'd11;
        #1;
        checks++; if (res_ready !== 1'b0 || pend_a !== 1'b1) begin errors++; $display("FAIL rmid_full got rdy=%0b pend=%0b exp 0/1", res_ready, pend_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_low got=%0b exp=0", res_ready); end
        tick();
        tick();
        dbg_we = 1'b0;
        res_valid = 1'b0;
        #1;
        checks++; if (flag_c !== 1'b0 || flag_z !== 1'b0 || wb_valid !== 1'b0 || wb_addr !== 4'd0) begin errors++; $display("FAIL rmid_regs got c=%0b z=%0b v=%0b a=%0d exp all 0", flag_c, flag_z, wb_valid, wb_addr); end
        checks++; if (pend_a !== 1'b0) begin errors++; $display("FAIL rmid_pend got=%0b exp=0", pend_a); end
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = AW'(i);
            #1;
            checks++; if (rd_data_a !== 20'h00000) begin errors++; $display("FAIL rmid_rf%0d got=%h exp=00000", i, rd_data_a); end
        end
        rst_n = 1'b1;
        #1;
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL rmid_release got=%0b exp=1", res_ready); end
        offer(20'hFFFFF, 1'b0, 1'b1, 4'd0);
        rd_addr_a = 4'd0;
        tick();
        res_valid = 1'b0;
        tick();
        checks++; if (wb_valid !== 1'b1 || flag_z !== 1'b0 || rd_data_a !== 20'hFFFFF) begin errors++; $display("FAIL rmid_post got v=%0b z=%0b d=%h exp 1/0/fffff", wb_valid, flag_z, rd_data_a); end
    endtask

    initial begin
        rst_n = 1'b0; res_valid = 1'b0; res_data = '0; res_cout = 1'b0; res_we = 1'b0;
        res_dest = '0; dbg_we = 1'b0; dbg_addr = '0; dbg_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        test_reset();
        test_basic_write();
        test_flags_only();
        test_back_to_back();
        test_bypass_pending();
        test_dbg_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
